// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx byte port between NUM_REQ requesters.
// A granted requester holds the port until its last byte, MAX_BURST bytes, or IDLE_TIMEOUT stall cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [8*NUM_REQ-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_busy
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   LAST_INIT  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [IDX_W-1:0]     grant_idx_r;
  logic [IDX_W-1:0]     last_winner_r;
  logic [BURST_W-1:0]   burst_cnt_r;
  logic [IDLE_W-1:0]    idle_cnt_r;

  logic                 any_req_s;
  logic                 pick_found_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic [IDX_W-1:0]     cand_idx_s;
  int                   cand_s;

  logic                 owner_valid_s;
  logic                 owner_last_s;
  logic [7:0]           owner_data_s;
  logic                 xfer_s;
  logic                 release_s;

  assign any_req_s     = |i_req_valid;
  assign owner_valid_s = i_req_valid[grant_idx_r];
  assign owner_last_s  = i_req_last[grant_idx_r];
  assign owner_data_s  = i_req_data[{grant_idx_r, 3'b000} +: 8];
  assign xfer_s        = (state_r == ST_GRANT) && owner_valid_s && i_tx_ready;

  // Release on last byte, full burst, or stall timeout; one release even if several coincide.
  assign release_s = (state_r == ST_GRANT) &&
                     ((xfer_s && owner_last_s) ||
                      (xfer_s && (burst_cnt_r == BURST_LAST)) ||
                      (!owner_valid_s && (idle_cnt_r == IDLE_LAST)));

  // Round-robin search starting just after the previous winner.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = 0;
    cand_idx_s   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s       = (int'(last_winner_r) + k) % NUM_REQ;
      cand_idx_s   = IDX_W'(cand_s);
      pick_idx_s   = (!pick_found_s && i_req_valid[cand_idx_s]) ? cand_idx_s : pick_idx_s;
      pick_found_s = pick_found_s | i_req_valid[cand_idx_s];
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          next_state_s = ST_GRANT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_GRANT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Owner index, round-robin pointer and burst/stall counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_idx_r   <= '0;
      last_winner_r <= LAST_INIT;
      burst_cnt_r   <= '0;
      idle_cnt_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant_idx_r <= pick_idx_s;
            burst_cnt_r <= '0;
            idle_cnt_r  <= '0;
          end
        end
        ST_GRANT: begin
          if (xfer_s) begin
            burst_cnt_r <= burst_cnt_r + BURST_W'(1);
          end
          if (owner_valid_s) begin
            idle_cnt_r <= '0;
          end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
          end
          if (release_s) begin
            last_winner_r <= grant_idx_r;
          end
        end
        default: begin
          grant_idx_r <= grant_idx_r;
        end
      endcase
    end
  end

  // Outputs: only the owner is passed through while granted; everything is zero in IDLE.
  always_comb begin
    o_tx_data   = 8'h00;
    o_tx_valid  = 1'b0;
    o_req_ready = '0;
    o_grant     = '0;
    o_busy      = 1'b0;
    case (state_r)
      ST_GRANT: begin
        o_tx_data                = owner_data_s;
        o_tx_valid               = owner_valid_s;
        o_req_ready[grant_idx_r] = i_tx_ready;
        o_grant[grant_idx_r]     = 1'b1;
        o_busy                   = 1'b1;
      end
      ST_IDLE: begin
        o_busy = 1'b0;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus random traffic, checked by a
// scoreboard fed from an abstract arbitration model and drained by an independent monitor.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 16;
  localparam int IT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [N-1:0]     grant;
  logic             busy;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_data  (req_data),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_grant     (grant),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Requester byte queues: bits [7:0] data, bit 8 = last.
  int rq [N][$];
  bit gap [N];
  bit rst_k, rdy_k, mon_en;

  // Abstract model state: owner (-1 = nobody), previous winner, bytes sent, idle cycles.
  int m_owner, m_lw, m_burst, m_idle;

  int cyc_q [$];    // per cycle: grant*4 + owner_valid*2 + handshake
  int byte_q [$];   // per transfer: requester*256 + data
  int served_q [$];
  int exp_seq [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_seq(input string nm);
    check({nm, "_len"}, served_q.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < served_q.size(); i++)
      check(nm, served_q[i], exp_seq[i]);
  endtask

  // One clock cycle: drive inputs, predict this cycle's response, advance the model.
  task automatic cycle();
    bit v [N];
    int e;
    int g;
    int pick;
    bit xf;
    bit rel;
    @(negedge clk);
    rst      = rst_k;
    tx_ready = rdy_k;
    for (int n = 0; n < N; n++) begin
      v[n] = (rq[n].size() > 0) && !gap[n];
      e = v[n] ? rq[n][0] : int'($urandom_range(0, 511));
      req_valid[n]        = v[n];
      req_data[8*n +: 8]  = e[7:0];
      req_last[n]         = e[8];
    end
    g  = (m_owner >= 0) ? (1 << m_owner) : 0;
    xf = (m_owner >= 0) && v[m_owner] && rdy_k;
    if (mon_en) cyc_q.push_back(g * 4 + ((m_owner >= 0 && v[m_owner]) ? 2 : 0) + (xf ? 1 : 0));
    e = 0;
    if (xf) begin
      e = rq[m_owner].pop_front();
      if (mon_en) byte_q.push_back(m_owner * 256 + int'(e[7:0]));
    end
    rel = 1'b0;
    if (rst_k) begin
      m_owner = -1; m_lw = N - 1; m_burst = 0; m_idle = 0;
    end else if (m_owner < 0) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && v[(m_lw + k) % N]) pick = (m_lw + k) % N;
      if (pick >= 0) begin
        m_owner = pick; m_burst = 0; m_idle = 0;
      end
    end else begin
      if (xf) begin
        m_burst++;
        m_idle = 0;
        rel = e[8] || (m_burst == MB);
      end else if (!v[m_owner]) begin
        m_idle++;
        rel = (m_idle == IT);
      end else begin
        m_idle = 0;
      end
      if (rel) begin
        m_lw = m_owner;
        m_owner = -1;
      end
    end
  endtask

  function automatic bit pending();
    bit p = (m_owner >= 0);
    for (int n = 0; n < N; n++) if (rq[n].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_until_idle(input int budget, input string nm);
    int c = 0;
    while (pending() && c < budget) begin
      cycle();
      c++;
    end
    check({nm, "_drained"}, pending(), 0);
    #3;
  endtask

  task automatic outputs_zero(input string nm);
    check({nm, "_grant"}, grant, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_tx_valid"}, tx_valid, 0);
    check({nm, "_req_ready"}, req_ready, 0);
    check({nm, "_tx_data"}, tx_data, 0);
  endtask

  // Monitor: pops the expected per-cycle response and compares with what the DUT presents.
  int mon_c, mon_b, mon_idx;
  bit mon_hs;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (cyc_q.size() > 0) begin
        mon_c   = cyc_q.pop_front();
        mon_idx = -1;
        for (int n = 0; n < N; n++) if (req_ready[n] && req_valid[n]) mon_idx = n;
        mon_hs = |(req_ready & req_valid);
        check("grant", grant, mon_c / 4);
        check("tx_valid", tx_valid, (mon_c / 2) % 2);
        check("handshake", mon_hs, mon_c % 2);
        if (mon_hs) begin
          served_q.push_back(mon_idx);
          if (byte_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got 0x%0h from req %0d, none expected", tx_data, mon_idx);
          end else begin
            mon_b = byte_q.pop_front();
            check("tx_owner", mon_idx, mon_b / 256);
            check("tx_data", tx_data, mon_b % 256);
          end
        end
        check("grant_onehot0", $onehot0(grant), 1);
        check("ready_onehot0", $onehot0(req_ready), 1);
        check("ready_without_tx_ready", (|req_ready) & !tx_ready, 0);
        check("tx_valid_in_idle", tx_valid & !busy, 0);
        check("busy_vs_grant", busy, |grant);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c;
  initial begin
    rst = 1'b1; tx_ready = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    rst_k = 1'b1; rdy_k = 1'b0; mon_en = 1'b0;
    m_owner = -1; m_lw = N - 1; m_burst = 0; m_idle = 0;
    for (int n = 0; n < N; n++) gap[n] = 1'b0;
    repeat (3) cycle();
    rst_k = 1'b0;
    mon_en = 1'b1;
    cycle(); #2;
    outputs_zero("reset");

    // 1: three-byte packet from requester 0 with a ready stall.
    served_q.delete();
    rq[0].push_back(32'h41); rq[0].push_back(32'h42); rq[0].push_back(32'h143);
    rdy_k = 1'b1;
    cycle(); #2; check("t1_arb_cycle", grant, 0);
    cycle(); #2; check("t1_granted", grant, 4'b0001);
    rdy_k = 1'b0;
    cycle(); #2; check("t1_ready_stall", req_ready, 0);
    rdy_k = 1'b1;
    cycle(); cycle();
    cycle(); #2; check("t1_released", grant, 0);
    exp_seq = '{0, 0, 0};
    check_seq("t1_order");

    // 2: everyone requests after requester 0 won.
    served_q.delete();
    for (int n = 0; n < N; n++) rq[n].push_back(32'h150 + n);
    run_until_idle(100, "t2");
    exp_seq = '{1, 2, 3, 0};
    check_seq("t2_order");

    // 3: burst limit forces a release mid-stream.
    served_q.delete();
    for (int i = 0; i < 20; i++) rq[2].push_back(32'h60 + i);
    cycle(); cycle();
    rq[1].push_back(32'h1AA);
    run_until_idle(200, "t3");
    exp_seq.delete();
    for (int i = 0; i < 16; i++) exp_seq.push_back(2);
    exp_seq.push_back(1);
    for (int i = 0; i < 4; i++) exp_seq.push_back(2);
    check_seq("t3_order");

    // 4: stall of IT-1 cycles keeps the grant, stall of IT cycles releases it.
    served_q.delete();
    rq[3].push_back(32'h71); rq[3].push_back(32'h72); rq[3].push_back(32'h173);
    c = 0;
    while (rq[3].size() > 2 && c < 10) begin cycle(); c++; end
    check("t4_first_byte", rq[3].size(), 2);
    gap[3] = 1'b1;
    repeat (IT - 1) cycle();
    #2; check("t4_hold_short_gap", grant, 4'b1000);
    gap[3] = 1'b0;
    cycle(); #2; check("t4_byte_after_gap", req_ready, 4'b1000);
    gap[3] = 1'b1;
    repeat (IT) cycle();
    #2; check("t4_hold_last_idle", grant, 4'b1000);
    cycle(); #2; check("t4_timeout_release", grant, 0);
    gap[3] = 1'b0;
    run_until_idle(50, "t4");
    exp_seq = '{3, 3, 3};
    check_seq("t4_order");

    // 5: reset during byte 2 of a four-byte packet.
    served_q.delete();
    rq[1].push_back(32'h181);
    run_until_idle(20, "t5a");
    rq[2].push_back(32'h91); rq[2].push_back(32'h92); rq[2].push_back(32'h93); rq[2].push_back(32'h194);
    c = 0;
    while (rq[2].size() > 3 && c < 10) begin cycle(); c++; end
    check("t5_first_byte", rq[2].size(), 3);
    rst_k = 1'b1; rdy_k = 1'b0;
    cycle();
    rst_k = 1'b0; rdy_k = 1'b1;
    rq[0].push_back(32'h1A0);
    rq[1].push_back(32'h1B1);
    cycle(); #2;
    outputs_zero("t5_after_reset");
    cycle(); #2; check("t5_priority_req0", grant, 4'b0001);
    run_until_idle(100, "t5");
    exp_seq = '{1, 2, 0, 1, 2, 2, 2};
    check_seq("t5_order");

    // Random traffic with stalls, gaps and packets with and without a last flag.
    for (int it = 0; it < 3000; it++) begin
      for (int n = 0; n < N; n++) begin
        if (rq[n].size() == 0 && $urandom_range(0, 9) == 0) begin
          int len;
          bit has_last;
          len = int'($urandom_range(1, 20));
          has_last = ($urandom_range(0, 4) != 0);
          for (int i = 0; i < len; i++)
            rq[n].push_back(int'($urandom_range(0, 255)) + ((has_last && i == len - 1) ? 256 : 0));
        end
        gap[n] = ($urandom_range(0, 5) == 0);
      end
      rdy_k = ($urandom_range(0, 3) != 0);
      cycle();
    end
    for (int n = 0; n < N; n++) gap[n] = 1'b0;
    rdy_k = 1'b1;
    run_until_idle(3000, "rand");

    #10;
    check("scoreboard_bytes_left", byte_q.size(), 0);
    check("scoreboard_cycles_left", cyc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
